bus_cycle_sequencer: RTL and testbench
======================================

BUS_CYCLE_SEQUENCER -- requirements
Module: bus_cycle_sequencer

Interface
REQ-001 SHALL have CLK  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have notRESET  in  1  asynchronous, active-low reset.
REQ-003 SHALL have cyc_req  in  1  level; requester asks for one bus machine cycle.
REQ-004 SHALL have cyc_type  in  3  0=M1 fetch, 1=mem read, 2=mem write, 3=IO read, 4=IO write, 5-7 illegal.
REQ-005 SHALL have notWAIT  in  1  active-low wait from bus.
REQ-006 SHALL have notBUSREQ  in  1  active-low external bus request.
REQ-007 SHALL have halt_req  in  1  level; core is halted.
REQ-008 SHALL have cyc_ack  out  1  one-clock pulse in the final T-state of an accepted cycle.
REQ-009 SHALL have din_latch  out  1  one-clock strobe telling the core to capture Din.
REQ-010 SHALL have busy  out  1  high in any state except IDLE.
REQ-011 SHALL have notPI_Flag_M1, _MREQ, _RD, _WR, _IORQ, _RFSH, _BUSAK, _HALT  out  1 each  active-low strobe requests to the bus interface.
REQ-012 SHALL have notPI_Activate_Ad_high, notPI_Activate_Ad_low, notPI_Activate_Dt  out  1 each  active-low bus drive enables.
REQ-013 SHALL have PI_SelectAdt1  out  1  high selects refresh address (IR) during M1 T3/T4.

Function
REQ-014 SHALL implement states IDLE, T1, T2, TW, T3, T4, GRANT; one CLK per T-state; all outputs registered.
REQ-015 SHALL sample requests only in IDLE or in the final T-state; notBUSREQ=0 has priority over cyc_req and moves to GRANT.
REQ-016 SHALL latch cyc_type on acceptance; cyc_type changes mid-cycle SHALL be ignored.
REQ-017 M1: T1,T2,TW M1=MREQ=RD=0; T3,T4 M1=RD=1, MREQ=RFSH=0, PI_SelectAdt1=1; din_latch in T3; cyc_ack in T4.
REQ-018 Mem read: T1-T3 MREQ=RD=0; din_latch and cyc_ack in T3.
REQ-019 Mem write: T1-T3 MREQ=0 and Activate_Dt=0; WR=0 in T2,TW,T3; cyc_ack in T3.
REQ-020 IO read/write: IORQ and RD (or WR) =0 in T2,TW,T3; one TW SHALL always be inserted after T2; IO write drives Activate_Dt=0 T1-T3; din_latch (read) and cyc_ack in T3.
REQ-021 Ad_high/Ad_low SHALL be 0 in T1-T4 of every cycle and 1 in IDLE and GRANT.
REQ-022 From T2 or TW, notWAIT=0 at the clock edge SHALL cause (re)entry to TW; unbounded wait count.
REQ-023 Illegal cyc_type: accepted, one T1 with all strobes inactive, cyc_ack in that T1, back to IDLE.
REQ-024 cyc_req high in the final T-state without bus request SHALL start the next T1 with no IDLE gap.
REQ-025 GRANT: BUSAK=0, all other strobes and enables 1; notBUSREQ=1 returns to IDLE next clock with BUSAK=1.
REQ-026 notPI_Flag_HALT SHALL equal registered ~halt_req, independent of state; cycles are still served while halted.

Reset
REQ-027 notRESET=0 SHALL immediately force IDLE, all not* outputs 1, PI_SelectAdt1=0, cyc_ack=din_latch=busy=0, including mid-cycle.
REQ-028 First acceptance after release SHALL occur no earlier than the first rising edge with notRESET=1.

Configuration
REQ-029 With BUSSEQ_WAIT_EN defined, notWAIT SHALL insert TW states per REQ-022.
REQ-030 Without BUSSEQ_WAIT_EN, notWAIT SHALL be ignored (port retained); the IO automatic TW of REQ-020 SHALL remain.

Verification
REQ-031 Reset, cyc_req=1, type=0, notWAIT=1 -> T1..T4 in 4 clocks; din_latch at clock 3, RFSH=0 clocks 3-4, cyc_ack clock 4.
REQ-032 Type=1, notWAIT=0 for 2 clocks from T2 -> two TW, cyc_ack at clock 5; without BUSSEQ_WAIT_EN cyc_ack at clock 3.
REQ-033 Type=4 -> IORQ=WR=0 clocks 2-4, Activate_Dt=0 clocks 1-4, cyc_ack clock 4.
REQ-034 notBUSREQ=0 with cyc_req=1 in IDLE -> GRANT, BUSAK=0, Ad enables 1; release -> IDLE, then T1.
REQ-035 notRESET pulsed low in T2 of mem write -> WR, MREQ, Activate_Dt at 1 with no clock edge; busy=0.

Source files
------------

// File: rtl/bus_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// bus_cycle_sequencer
//   Sequences one bus machine cycle at a time (M1 fetch, memory read/write,
//   IO read/write) through T-states and drives the active-low strobe and
//   bus-drive requests for the pin interface. It also handles external bus
//   request/grant and the halt flag.
//
//   Every output is a flop. The next-state decode also produces the output
//   values of the state being entered, so the outputs always match the state
//   that is current.
//
// Ports
//   CLK, notRESET           clock, asynchronous active-low reset
//   cyc_req, cyc_type[2:0]  cycle request (level) and type; the type is
//                           latched when the request is accepted
//   notWAIT                 bus wait (active low)
//   notBUSREQ               external bus request (active low)
//   halt_req                core halted (level)
//   cyc_ack, din_latch      one-clock strobes to the core
//   busy                    high when not in IDLE
//   notPI_Flag_*            active-low strobe requests
//   notPI_Activate_*        active-low bus drive enables
//   PI_SelectAdt1           selects the refresh address during M1 T3/T4
//
// Configuration
//   BUSSEQ_WAIT_EN  when defined, notWAIT=0 inserts or extends TW states.
//                   When it is not defined, notWAIT is ignored. The automatic
//                   IO TW is still inserted.
// -----------------------------------------------------------------------------
module bus_cycle_sequencer (
    input  logic       CLK,
    input  logic       notRESET,
    input  logic       cyc_req,
    input  logic [2:0] cyc_type,
    input  logic       notWAIT,
    input  logic       notBUSREQ,
    input  logic       halt_req,
    output logic       cyc_ack,
    output logic       din_latch,
    output logic       busy,
    output logic       notPI_Flag_M1,
    output logic       notPI_Flag_MREQ,
    output logic       notPI_Flag_RD,
    output logic       notPI_Flag_WR,
    output logic       notPI_Flag_IORQ,
    output logic       notPI_Flag_RFSH,
    output logic       notPI_Flag_BUSAK,
    output logic       notPI_Flag_HALT,
    output logic       notPI_Activate_Ad_high,
    output logic       notPI_Activate_Ad_low,
    output logic       notPI_Activate_Dt,
    output logic       PI_SelectAdt1
);

    typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, T4, GRANT} state_t;

    localparam logic [2:0] TY_M1   = 3'd0;
    localparam logic [2:0] TY_MRD  = 3'd1;
    localparam logic [2:0] TY_MWR  = 3'd2;
    localparam logic [2:0] TY_IORD = 3'd3;
    localparam logic [2:0] TY_IOWR = 3'd4;

`ifdef BUSSEQ_WAIT_EN
    localparam logic WAIT_EN = 1'b1;
`else
    localparam logic WAIT_EN = 1'b0;
`endif

    state_t     state, nextState;
    logic [2:0] cycType, nextType;
    logic       isFinal, waitActive;

    // Output values for the state being entered.
    logic nAck, nDin, nBusy, nM1, nMreq, nRd, nWr, nIorq, nRfsh, nBusak, nHalt;
    logic nAdHigh, nAdLow, nDt, nSel;

    assign waitActive = WAIT_EN & ~notWAIT;

    // Final T-state of the current cycle. Requests are sampled here and in IDLE.
    always_comb begin
        isFinal = 1'b0;
        case (state)
            T1:      isFinal = (cycType > TY_IOWR);   // illegal type: one T1 only
            T3:      isFinal = (cycType != TY_M1);    // M1 goes on to T4
            T4:      isFinal = 1'b1;
            default: isFinal = 1'b0;
        endcase
    end

    always_comb begin
        nextState = state;
        nextType  = cycType;
        if (state == IDLE || isFinal) begin
            if (!notBUSREQ) begin
                nextState = GRANT;
            end else if (cyc_req) begin
                nextState = T1;
                nextType  = cyc_type;
            end else begin
                nextState = IDLE;
            end
        end else begin
            case (state)
                T1:      nextState = T2;
                // IO cycles always get one TW after T2.
                T2:      nextState = (waitActive || cycType == TY_IORD || cycType == TY_IOWR) ? TW : T3;
                TW:      nextState = waitActive ? TW : T3;
                T3:      nextState = T4;
                GRANT:   nextState = notBUSREQ ? IDLE : GRANT;
                default: nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        logic inCyc, early, mid, thru3;
        nAck = 1'b0;  nDin = 1'b0;  nBusy = (nextState != IDLE);
        nM1 = 1'b1;   nMreq = 1'b1; nRd = 1'b1;  nWr = 1'b1;
        nIorq = 1'b1; nRfsh = 1'b1; nBusak = 1'b1;
        nHalt = ~halt_req;
        nAdHigh = 1'b1; nAdLow = 1'b1; nDt = 1'b1; nSel = 1'b0;

        inCyc = (nextState == T1) || (nextState == T2) || (nextState == TW) ||
                (nextState == T3) || (nextState == T4);
        early = (nextState == T1) || (nextState == T2) || (nextState == TW);
        mid   = (nextState == T2) || (nextState == TW) || (nextState == T3);
        thru3 = early || (nextState == T3);

        if (inCyc) begin
            nAdHigh = 1'b0;
            nAdLow  = 1'b0;
            case (nextType)
                TY_M1: begin
                    if (early) begin
                        nM1 = 1'b0; nMreq = 1'b0; nRd = 1'b0;
                    end else begin
                        // T3/T4: refresh with the IR address
                        nMreq = 1'b0; nRfsh = 1'b0; nSel = 1'b1;
                    end
                    nDin = (nextState == T3);
                    nAck = (nextState == T4);
                end
                TY_MRD: begin
                    if (thru3) begin nMreq = 1'b0; nRd = 1'b0; end
                    nDin = (nextState == T3);
                    nAck = (nextState == T3);
                end
                TY_MWR: begin
                    if (thru3) begin nMreq = 1'b0; nDt = 1'b0; end
                    if (mid)   nWr = 1'b0;
                    nAck = (nextState == T3);
                end
                TY_IORD: begin
                    if (mid) begin nIorq = 1'b0; nRd = 1'b0; end
                    nDin = (nextState == T3);
                    nAck = (nextState == T3);
                end
                TY_IOWR: begin
                    if (mid)   begin nIorq = 1'b0; nWr = 1'b0; end
                    if (thru3) nDt = 1'b0;
                    nAck = (nextState == T3);
                end
                default: nAck = (nextState == T1);   // illegal: acknowledge and drop
            endcase
        end else if (nextState == GRANT) begin
            nBusak = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            state   <= IDLE;
            cycType <= TY_M1;
            cyc_ack <= 1'b0;  din_latch <= 1'b0;  busy <= 1'b0;
            notPI_Flag_M1   <= 1'b1; notPI_Flag_MREQ  <= 1'b1;
            notPI_Flag_RD   <= 1'b1; notPI_Flag_WR    <= 1'b1;
            notPI_Flag_IORQ <= 1'b1; notPI_Flag_RFSH  <= 1'b1;
            notPI_Flag_BUSAK <= 1'b1; notPI_Flag_HALT <= 1'b1;
            notPI_Activate_Ad_high <= 1'b1; notPI_Activate_Ad_low <= 1'b1;
            notPI_Activate_Dt <= 1'b1; PI_SelectAdt1 <= 1'b0;
        end else begin
            state   <= nextState;
            cycType <= nextType;
            cyc_ack <= nAck;  din_latch <= nDin;  busy <= nBusy;
            notPI_Flag_M1   <= nM1;   notPI_Flag_MREQ  <= nMreq;
            notPI_Flag_RD   <= nRd;   notPI_Flag_WR    <= nWr;
            notPI_Flag_IORQ <= nIorq; notPI_Flag_RFSH  <= nRfsh;
            notPI_Flag_BUSAK <= nBusak; notPI_Flag_HALT <= nHalt;
            notPI_Activate_Ad_high <= nAdHigh; notPI_Activate_Ad_low <= nAdLow;
            notPI_Activate_Dt <= nDt; PI_SelectAdt1 <= nSel;
        end
    end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bus_cycle_sequencer
//   Directed bench for bus_cycle_sequencer. The outputs are packed into one
//   vector:
//     {cyc_ack, din_latch, busy,
//      M1, MREQ, RD, WR, IORQ, RFSH, BUSAK, HALT,
//      Ad_high, Ad_low, Dt, SelectAdt1}
//   Each step is checked against a hand-written expected value.
// -----------------------------------------------------------------------------
module tb_bus_cycle_sequencer;

    logic       CLK = 1'b0;
    logic       notRESET, cyc_req, notWAIT, notBUSREQ, halt_req;
    logic [2:0] cyc_type;
    logic cyc_ack, din_latch, busy;
    logic notPI_Flag_M1, notPI_Flag_MREQ, notPI_Flag_RD, notPI_Flag_WR;
    logic notPI_Flag_IORQ, notPI_Flag_RFSH, notPI_Flag_BUSAK, notPI_Flag_HALT;
    logic notPI_Activate_Ad_high, notPI_Activate_Ad_low, notPI_Activate_Dt, PI_SelectAdt1;

    int errors = 0;
    int checks = 0;

    logic [14:0] obs;
    assign obs = {cyc_ack, din_latch, busy,
                  notPI_Flag_M1, notPI_Flag_MREQ, notPI_Flag_RD, notPI_Flag_WR,
                  notPI_Flag_IORQ, notPI_Flag_RFSH, notPI_Flag_BUSAK, notPI_Flag_HALT,
                  notPI_Activate_Ad_high, notPI_Activate_Ad_low, notPI_Activate_Dt,
                  PI_SelectAdt1};

    localparam logic [14:0] IDLE_V = 15'b000_11111111_111_0;

    bus_cycle_sequencer dut (
        .CLK(CLK), .notRESET(notRESET), .cyc_req(cyc_req), .cyc_type(cyc_type),
        .notWAIT(notWAIT), .notBUSREQ(notBUSREQ), .halt_req(halt_req),
        .cyc_ack(cyc_ack), .din_latch(din_latch), .busy(busy),
        .notPI_Flag_M1(notPI_Flag_M1), .notPI_Flag_MREQ(notPI_Flag_MREQ),
        .notPI_Flag_RD(notPI_Flag_RD), .notPI_Flag_WR(notPI_Flag_WR),
        .notPI_Flag_IORQ(notPI_Flag_IORQ), .notPI_Flag_RFSH(notPI_Flag_RFSH),
        .notPI_Flag_BUSAK(notPI_Flag_BUSAK), .notPI_Flag_HALT(notPI_Flag_HALT),
        .notPI_Activate_Ad_high(notPI_Activate_Ad_high),
        .notPI_Activate_Ad_low(notPI_Activate_Ad_low),
        .notPI_Activate_Dt(notPI_Activate_Dt), .PI_SelectAdt1(PI_SelectAdt1)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [14:0] expected);
        checks++;
        assert (obs === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expected);
        end
    endtask

    initial begin
        notRESET = 1'b0; cyc_req = 1'b1; cyc_type = 3'd0;
        notWAIT = 1'b1; notBUSREQ = 1'b1; halt_req = 1'b0;

        // A request held during reset must not be accepted.
        step(); chk("rst_idle0", IDLE_V);
        step(); chk("rst_idle1", IDLE_V);
        #2 notRESET = 1'b1;

        // M1 fetch. A cyc_type change in the middle of the cycle is ignored.
        step(); chk("m1_t1", 15'b001_00011111_001_0);
        cyc_req = 1'b0; cyc_type = 3'd3;
        step(); chk("m1_t2", 15'b001_00011111_001_0);
        step(); chk("m1_t3", 15'b011_10111011_001_1);
        step(); chk("m1_t4", 15'b101_10111011_001_1);
        step(); chk("m1_idle", IDLE_V);

        // Memory read. notWAIT is low for two clocks starting in T2.
        cyc_req = 1'b1; cyc_type = 3'd1;
        step(); chk("rd_t1", 15'b001_10011111_001_0);
        cyc_req = 1'b0;
        step(); chk("rd_t2", 15'b001_10011111_001_0);
        notWAIT = 1'b0;
`ifdef BUSSEQ_WAIT_EN
        step(); chk("rd_tw1", 15'b001_10011111_001_0);
        step(); chk("rd_tw2", 15'b001_10011111_001_0);
        notWAIT = 1'b1;
        step(); chk("rd_t3", 15'b111_10011111_001_0);
        step(); chk("rd_idle", IDLE_V);
`else
        step(); chk("rd_t3", 15'b111_10011111_001_0);
        step(); chk("rd_idle", IDLE_V);
        notWAIT = 1'b1;
`endif

        // IO write followed by a memory write with no IDLE between them.
        cyc_req = 1'b1; cyc_type = 3'd4;
        step(); chk("iow_t1", 15'b001_11111111_000_0);
        step(); chk("iow_t2", 15'b001_11100111_000_0);
        cyc_type = 3'd2;
        step(); chk("iow_tw", 15'b001_11100111_000_0);
        step(); chk("iow_t3", 15'b101_11100111_000_0);
        step(); chk("wr_t1", 15'b001_10111111_000_0);
        cyc_req = 1'b0;
        step(); chk("wr_t2", 15'b001_10101111_000_0);

        // Reset in the middle of the cycle must take effect with no clock edge.
        #2 notRESET = 1'b0;
        #1 chk("rst_mid", IDLE_V);
        #1 notRESET = 1'b1;
        step(); chk("rst_mid_idle", IDLE_V);

        // A bus request takes priority over a pending cycle request.
        cyc_req = 1'b1; cyc_type = 3'd1; notBUSREQ = 1'b0;
        step(); chk("grant0", 15'b001_11111101_111_0);
        step(); chk("grant1", 15'b001_11111101_111_0);
        notBUSREQ = 1'b1;
        step(); chk("grant_rel_idle", IDLE_V);
        step(); chk("grd_t1", 15'b001_10011111_001_0);
        cyc_req = 1'b0;
        step(); chk("grd_t2", 15'b001_10011111_001_0);
        notBUSREQ = 1'b0;
        step(); chk("grd_t3", 15'b111_10011111_001_0);
        step(); chk("grant_final", 15'b001_11111101_111_0);
        notBUSREQ = 1'b1;
        step(); chk("grant_final_idle", IDLE_V);

        // Illegal cycle type while halted: a single T1 that is acknowledged.
        halt_req = 1'b1; cyc_req = 1'b1; cyc_type = 3'd6;
        step(); chk("ill_t1", 15'b101_11111110_001_0);
        cyc_req = 1'b0;
        step(); chk("halt_idle", 15'b000_11111110_111_0);
        halt_req = 1'b0;

        // IO read.
        cyc_req = 1'b1; cyc_type = 3'd3;
        step(); chk("ior_t1", 15'b001_11111111_001_0);
        cyc_req = 1'b0;
        step(); chk("ior_t2", 15'b001_11010111_001_0);
        step(); chk("ior_tw", 15'b001_11010111_001_0);
        step(); chk("ior_t3", 15'b111_11010111_001_0);
        step(); chk("ior_idle", IDLE_V);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
